// File: rtl/bus_write_router_if.sv
// Request/slot bus between a CPU-side requester and the write router.
// master = requester/slot side, slave = router side.
interface bus_write_router_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_wdata;
    logic              req_ready;
    logic [3:0]        slot_ready;
    logic [3:0]        cs_o;
    logic              we_o;
    logic [WIDTH-1:0]  wdata_o;
    logic [7:0]        addr_o;
    logic [1:0]        rd_sel;
    logic              resp_valid;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, slot_ready,
        input  req_ready, cs_o, we_o, wdata_o, addr_o, rd_sel, resp_valid, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, slot_ready,
        output req_ready, cs_o, we_o, wdata_o, addr_o, rd_sel, resp_valid, resp_err
    );
endinterface

// File: rtl/bus_write_router.sv
// Routes a single CPU access to one of four slots selected by req_addr[9:8],
// waits for that slot's ready (bounded by TIMEOUT) and returns a one-cycle response.
//
// state  | meaning
// IDLE   | ready to accept a request
// WAIT   | slot selected, waiting for slot_ready[sel] or timeout
// RESP   | one-cycle resp_valid pulse, resp_err flags a timeout
module bus_write_router #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    bus_write_router_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Count value seen in the last allowed WAIT cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic              we_q, we_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              unused_addr;
    assign unused_addr = ^bus.req_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= 2'b00;
            we_q    <= 1'b0;
            wdata_q <= '0;
            addr_q  <= 8'h00;
            cnt_q   <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_d = S_WAIT;
                    sel_d   = bus.req_addr[9:8];
                    we_d    = bus.req_we;
                    wdata_d = bus.req_wdata;
                    addr_d  = bus.req_addr[7:0];
                    cnt_d   = 8'h00;
                    err_d   = 1'b0;
                end
            end
            S_WAIT: begin
                // A ready slot wins over a timeout reached in the same cycle.
                if (bus.slot_ready[sel_q]) begin
                    state_d = S_RESP;
                    err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.cs_o       = (state_q == S_WAIT) ? (4'b0001 << sel_q) : 4'b0000;
    assign bus.we_o       = (state_q == S_WAIT) && we_q;
    assign bus.wdata_o    = wdata_q;
    assign bus.addr_o     = addr_q;
    assign bus.rd_sel     = sel_q;
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_err   = (state_q == S_RESP) && err_q;

endmodule

// File: doc/bus_write_router.md
BUS_WRITE_ROUTER -- requirements
Module: bus_write_router

Interface
REQ-001 Parameter WIDTH, default 32: data width of the request write data and the slot write data.
REQ-002 Parameter ADDR_W, default 32: request address width; must be at least 10.
REQ-003 Parameter TIMEOUT, default 16, range 2..255: maximum number of WAIT cycles before an access aborts.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 req_valid  input  1  CPU access request.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  ADDR_W  access address; bits [9:8] select the slot.
REQ-009 req_wdata  input  WIDTH  write data.
REQ-010 req_ready  output  1  router can accept a request.
REQ-011 slot_ready  input  4  per-slot completion; bit k belongs to slot k.
REQ-012 cs_o  output  4  one-hot slot chip-select.
REQ-013 we_o  output  1  write strobe, qualified by cs_o.
REQ-014 wdata_o  output  WIDTH  registered write data, shared by all slots.
REQ-015 addr_o  output  8  registered req_addr[7:0], the slot-local offset.
REQ-016 rd_sel  output  2  select code for the 4:1 read-data mux.
REQ-017 resp_valid  output  1  one-cycle completion pulse.
REQ-018 resp_err  output  1  qualifies resp_valid; 1 = timeout abort.

Function
REQ-019 States: IDLE, WAIT and RESP; the encoding is free.
REQ-020 In IDLE, req_ready shall be 1; in WAIT and RESP it shall be 0.
REQ-021 On a clock edge in IDLE with req_valid=1, the block shall latch sel=req_addr[9:8], req_we, req_wdata and req_addr[7:0], clear the timeout counter and go to WAIT.
REQ-022 In WAIT, cs_o shall be the one-hot code of sel; in every other state cs_o shall be 4'b0000.
REQ-023 In WAIT, we_o shall equal the latched req_we; in every other state we_o shall be 0.
REQ-024 wdata_o and addr_o shall hold the latched values from acceptance until the next acceptance.
REQ-025 rd_sel shall load sel at acceptance and hold it through WAIT and RESP and after RESP, until the next acceptance.
REQ-026 In WAIT, if slot_ready[sel]=1, the block shall go to RESP with resp_err=0.
REQ-027 In WAIT, if slot_ready[sel]=0, the counter shall increment; if the count reaches TIMEOUT-1, the block shall go to RESP with resp_err=1.
REQ-028 If slot_ready[sel]=1 in the same cycle that the timeout limit is reached, the ready path shall win and resp_err shall be 0.
REQ-029 In RESP, resp_valid shall be 1 for exactly one cycle, then the block shall return to IDLE.
REQ-030 resp_err shall be 0 whenever resp_valid is 0.
REQ-031 The minimum latency from acceptance edge to resp_valid high shall be 2 cycles, with a ready slot in the first WAIT cycle.
REQ-032 The maximum latency shall be TIMEOUT+1 cycles.
REQ-033 slot_ready bits other than slot_ready[sel], and all slot_ready bits outside WAIT, shall be ignored.
REQ-034 req_valid shall be ignored while req_ready=0; the requester holds its request until accepted.
REQ-035 Back-to-back operation: a request held valid during RESP shall be accepted in the IDLE cycle that follows.

Reset
REQ-036 On a clock edge with rst_n=0, the state shall become IDLE regardless of the current state.
REQ-037 Reset values: cs_o=0, we_o=0, resp_valid=0, resp_err=0, rd_sel=2'b00, wdata_o=0, addr_o=0, counter=0, req_ready=1 from the first cycle after reset.
REQ-038 Reset during WAIT or RESP shall abandon the access with no resp_valid; slot strobes shall drop on the reset edge.

Verification
REQ-039 Write addr=0x0000_0204, data=0xDEAD_BEEF, slot_ready[2]=1 immediately: cs_o=4'b0100, we_o=1 and addr_o=0x04 for 1 cycle; then resp_valid=1, resp_err=0, rd_sel=2'b10.
REQ-040 Read addr=0x0000_0310, slot_ready[3] high after 3 WAIT cycles: we_o=0, cs_o=4'b1000 for 4 cycles; resp_valid on the 5th cycle after acceptance; rd_sel=2'b11 held afterward.
REQ-041 TIMEOUT=16, access to slot 1 with slot_ready=4'b1101 permanently: 16 WAIT cycles, then resp_valid=1, resp_err=1, then req_ready=1.
REQ-042 TIMEOUT=16, slot_ready[0] rises in WAIT cycle 16 (the limit cycle): resp_err=0.
REQ-043 rst_n=0 in the 2nd WAIT cycle of a write: on the next edge cs_o=0, we_o=0 and req_ready=1; no resp_valid is ever seen for that access.
REQ-044 req_valid held high across 3 requests to slots 0, 1, 2, all ready immediately: 3 resp_valid pulses spaced 3 cycles apart, and rd_sel follows 0, 1, 2.
